// File: rtl/sb_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// sb_frame_rx_pkg
// Shared definitions for the snoop-bus frame receiver:
//   - receiver FSM state encodings (plain 3-bit constants)
//   - frame delimiter bytes and the frame length
//   - frame_err cause codes
// ---------------------------------------------------------------------------
package sb_frame_rx_pkg;

  typedef logic [2:0] tsb_rx_state_t;

  localparam tsb_rx_state_t ST_IDLE = 3'd0;
  localparam tsb_rx_state_t ST_TYPE = 3'd1;
  localparam tsb_rx_state_t ST_SIZE = 3'd2;
  localparam tsb_rx_state_t ST_DATA = 3'd3;
  localparam tsb_rx_state_t ST_CHK  = 3'd4;
  localparam tsb_rx_state_t ST_END  = 3'd5;
  localparam tsb_rx_state_t ST_HOLD = 3'd6;

  localparam logic [7:0] SB_START_BYTE  = 8'hA5;
  localparam logic [7:0] SB_END_BYTE    = 8'h5A;
  localparam int         SB_FRAME_BYTES = 9;

  localparam logic [1:0] SB_ERR_NONE    = 2'b00;
  localparam logic [1:0] SB_ERR_BAD_END = 2'b01;
  localparam logic [1:0] SB_ERR_CHECK   = 2'b10;
  localparam logic [1:0] SB_ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/sb_rx_timeout.sv
// ---------------------------------------------------------------------------
// sb_rx_timeout
// Inter-byte idle counter. Counts cycles while 'active' and no byte is
// accepted; any accepted byte ('kick') or leaving the active window clears
// it. 'expire' is asserted combinationally on the cycle the count would
// reach TIMEOUT, so a byte arriving on that same cycle suppresses it.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   active      receiver is inside a frame (TYPE..END)
//   kick        a byte is accepted this cycle
//   expire      idle limit reached this cycle
// ---------------------------------------------------------------------------
module sb_rx_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic kick,
  output logic expire
);

  localparam int             W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]   TERM = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    expire = active && !kick && (cnt_q == TERM);
    if (!active || kick || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sb_frame_rx.sv
// ---------------------------------------------------------------------------
// sb_frame_rx
// Byte-serial receiver for the snoop-bus frame:
//   Start, Type, Size, Data[31:24..7:0], Error(check), End
// Verifies the End delimiter and the XOR check byte, aborts stalled frames,
// and holds a complete frame on out_* until the consumer takes it.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_data/in_ready   8-bit byte link (accept = valid && ready)
//   out_valid/out_ready    frame handshake
//   out_type/out_size/out_data/out_error  last delivered frame fields
//   frame_err, err_code    one-cycle drop pulse and its (sticky) cause
// ---------------------------------------------------------------------------
module sb_frame_rx
  import sb_frame_rx_pkg::*;
#(
  parameter logic [7:0] START_BYTE = SB_START_BYTE,
  parameter logic [7:0] END_BYTE   = SB_END_BYTE,
  parameter int         TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_type,
  output logic [7:0]  out_size,
  output logic [31:0] out_data,
  output logic [7:0]  out_error,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  tsb_rx_state_t state_q, state_d;
  logic [7:0]  xor_q, xor_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        mism_q, mism_d;
  // Shadow fields collect the frame in flight; out_* only change on a good End
  // so a dropped frame never disturbs the last delivered values.
  logic [7:0]  sh_type_q, sh_type_d;
  logic [7:0]  sh_size_q, sh_size_d;
  logic [31:0] sh_data_q, sh_data_d;
  logic [7:0]  sh_error_q, sh_error_d;
  logic [7:0]  out_type_q, out_type_d;
  logic [7:0]  out_size_q, out_size_d;
  logic [31:0] out_data_q, out_data_d;
  logic [7:0]  out_error_q, out_error_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic accept;
  logic tmo_active;
  logic tmo_expire;

  assign accept     = in_valid && in_ready_q;
  assign tmo_active = (state_q >= ST_TYPE) && (state_q <= ST_END);

  sb_rx_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (tmo_active),
    .kick   (accept),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d     = state_q;
    xor_d       = xor_q;
    byte_cnt_d  = byte_cnt_q;
    mism_d      = mism_q;
    sh_type_d   = sh_type_q;
    sh_size_d   = sh_size_q;
    sh_data_d   = sh_data_q;
    sh_error_d  = sh_error_q;
    out_type_d  = out_type_q;
    out_size_d  = out_size_q;
    out_data_d  = out_data_q;
    out_error_d = out_error_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;

    if (tmo_expire) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = SB_ERR_TIMEOUT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (in_data == START_BYTE)) state_d = ST_TYPE;
        end
        ST_TYPE: begin
          if (accept) begin
            sh_type_d = in_data;
            xor_d     = in_data;
            state_d   = ST_SIZE;
          end
        end
        ST_SIZE: begin
          if (accept) begin
            sh_size_d  = in_data;
            xor_d      = xor_q ^ in_data;
            byte_cnt_d = 2'd3;
            state_d    = ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            // MSB-first: count 3 lands in [31:24], count 0 in [7:0]
            sh_data_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
            xor_d = xor_q ^ in_data;
            if (byte_cnt_q == 2'd0) begin
              state_d = ST_CHK;
            end else begin
              byte_cnt_d = byte_cnt_q - 2'd1;
            end
          end
        end
        ST_CHK: begin
          if (accept) begin
            sh_error_d = in_data;
            mism_d     = (in_data != xor_q);
            state_d    = ST_END;
          end
        end
        ST_END: begin
          if (accept) begin
            if (in_data != END_BYTE) begin
              frame_err_d = 1'b1;
              err_code_d  = SB_ERR_BAD_END;
              state_d     = ST_IDLE;
            end else if (mism_q) begin
              frame_err_d = 1'b1;
              err_code_d  = SB_ERR_CHECK;
              state_d     = ST_IDLE;
            end else begin
              out_type_d  = sh_type_q;
              out_size_d  = sh_size_q;
              out_data_d  = sh_data_q;
              out_error_d = sh_error_q;
              out_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Registered so in_ready is 0 while reset is held and tracks HOLD exactly.
    in_ready_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      xor_q       <= '0;
      byte_cnt_q  <= '0;
      mism_q      <= 1'b0;
      sh_type_q   <= '0;
      sh_size_q   <= '0;
      sh_data_q   <= '0;
      sh_error_q  <= '0;
      out_type_q  <= '0;
      out_size_q  <= '0;
      out_data_q  <= '0;
      out_error_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= SB_ERR_NONE;
    end else begin
      state_q     <= state_d;
      xor_q       <= xor_d;
      byte_cnt_q  <= byte_cnt_d;
      mism_q      <= mism_d;
      sh_type_q   <= sh_type_d;
      sh_size_q   <= sh_size_d;
      sh_data_q   <= sh_data_d;
      sh_error_q  <= sh_error_d;
      out_type_q  <= out_type_d;
      out_size_q  <= out_size_d;
      out_data_q  <= out_data_d;
      out_error_q <= out_error_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_type  = out_type_q;
  assign out_size  = out_size_q;
  assign out_data  = out_data_q;
  assign out_error = out_error_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sb_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_sb_frame_rx
// Scoreboard bench for sb_frame_rx. Each driven frame pushes its expected
// outcome (delivered fields or error code); a negedge monitor pops and
// compares on every out handshake and every frame_err pulse.
// ---------------------------------------------------------------------------
module tb_sb_frame_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_type;
  logic [7:0]  out_size;
  logic [31:0] out_data;
  logic [7:0]  out_error;
  logic        frame_err;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  sb_frame_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_type  (out_type),
    .out_size  (out_size),
    .out_data  (out_data),
    .out_error (out_error),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  t;
    logic [7:0]  s;
    logic [31:0] d;
    logic [7:0]  e;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] last_d = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: outputs are stable at negedge; inputs only change at posedge+1.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("kind_frame", 0, 64'(e.is_err));
          check("out_type", 64'(out_type), 64'(e.t));
          check("out_size", 64'(out_size), 64'(e.s));
          check("out_data", 64'(out_data), 64'(e.d));
          check("out_error", 64'(out_error), 64'(e.e));
        end
        $display("frame  t=%h s=%h d=%h e=%h", out_type, out_size, out_data, out_error);
      end
      if (frame_err) begin
        if (sbq.size() == 0) begin
          check("unexpected_err", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("kind_err", 1, 64'(e.is_err));
          check("err_code", 64'(err_code), 64'(e.code));
        end
        $display("error  code=%0d", err_code);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [7:0] s, input logic [31:0] d,
                            input logic [7:0] flip, input logic [7:0] eb, input int stall);
    exp_t e;
    logic [7:0] x;
    x = t ^ s ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    e.t = t; e.s = s; e.d = d; e.e = x;
    if (eb != 8'h5A) begin
      e.is_err = 1'b1; e.code = 2'b01;
    end else if (flip != 8'h00) begin
      e.is_err = 1'b1; e.code = 2'b10;
    end else begin
      e.is_err = 1'b0; e.code = 2'b00; last_d = d;
    end
    sbq.push_back(e);
    send_byte(8'hA5);
    send_byte(t);
    send_byte(s);
    tick(stall);
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(x ^ flip);
    send_byte(eb);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick(1);
      n++;
    end
    check("valid_wait", 64'(out_valid), 1);
  endtask

  initial begin
    exp_t e;
    logic [55:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(1);
    check("reset_outs", {in_ready, out_valid, out_type, out_size, out_data, out_error, frame_err, err_code}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("ready_after_reset", 64'(in_ready), 1);

    // Clean frame, latency 1 cycle after End
    send_frame(8'h01, 8'h04, 32'hDEADBEEF, 8'h00, 8'h5A, 0);
    check("latency", 64'(out_valid), 1);
    check("hold_in_ready", 64'(in_ready), 0);
    tick(3);

    // Hunt: garbage before Start is discarded
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_frame(8'h12, 8'h34, 32'h0A5A5A5A, 8'h00, 8'h5A, 0);
    tick(3);

    // Bad End, check mismatch, both; out_* must keep last delivered values
    send_frame(8'h33, 8'h08, 32'h11223344, 8'h00, 8'h5B, 0);
    tick(2);
    check("keep_after_bad_end", 64'(out_data), 64'(last_d));
    check("no_valid_after_err", 64'(out_valid), 0);
    send_frame(8'h44, 8'h02, 32'hCAFEF00D, 8'h01, 8'h5A, 0);
    send_frame(8'h55, 8'h01, 32'h00000000, 8'h01, 8'h5B, 0);
    send_frame(8'hA5, 8'hA5, 32'hA5A5A5A5, 8'h00, 8'h5A, 0);
    tick(3);

    // Timeout: 16 idle cycles after Size aborts
    e.is_err = 1'b1; e.code = 2'b11; e.t = '0; e.s = '0; e.d = '0; e.e = '0;
    sbq.push_back(e);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h04);
    tick(16);
    tick(2);
    check("idle_after_tmo", 64'(in_ready), 1);
    // 15 idle cycles is tolerated
    send_frame(8'h66, 8'h04, 32'h87654321, 8'h00, 8'h5A, 15);
    tick(3);

    // Backpressure
    out_ready = 1'b0;
    send_frame(8'h77, 8'h04, 32'h13579BDF, 8'h00, 8'h5A, 0);
    wait_valid();
    held = {out_type, out_size, out_data, out_error};
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("hold_stable", 64'({out_type, out_size, out_data, out_error}), 64'(held));
    end
    check("hold_ready_valid", {in_ready, out_valid}, 2'b01);
    out_ready = 1'b1;
    tick(1);
    check("release_ready_valid", {in_ready, out_valid}, 2'b10);
    tick(2);

    // Reset mid-DATA drops the partial frame silently
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04); send_byte(8'hDE);
    rst_n = 1'b0;
    #1;
    check("midreset_outs", {in_ready, out_valid, out_type, out_size, out_data, out_error, frame_err, err_code}, 0);
    tick(3);
    rst_n = 1'b1;
    send_frame(8'h01, 8'h04, 32'hDEADBEEF, 8'h00, 8'h5A, 0);
    tick(4);

    check("sb_empty", 64'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
